// File: rtl/filter_median_stream_pkg.sv
// Shared constants and the sideband tag carried alongside the median pipeline.
// The MEDIAN_BYPASS_EN macro adds a bypass bit to the tag.
package filter_pkg;

    localparam int unsigned PIXEL_BIT_DEF = 8;
    localparam int unsigned LATENCY       = 4;

    localparam int unsigned TAG_VALID  = 0;
    localparam int unsigned TAG_SOF    = 1;
    localparam int unsigned TAG_EOL    = 2;
    localparam int unsigned TAG_BYPASS = 3;

`ifdef MEDIAN_BYPASS_EN
    localparam int unsigned TAG_W = 4;

    typedef struct packed {
        logic bypass;
        logic eol;
        logic sof;
        logic valid;
    } tag_t;
`else
    localparam int unsigned TAG_W = 3;

    typedef struct packed {
        logic eol;
        logic sof;
        logic valid;
    } tag_t;
`endif

endpackage

// File: rtl/filter_median_stream_sort3.sv
// Combinational 3-input sorter returning min/mid/max; equal inputs keep their order.
module sort3
    import filter_pkg::*;
#(
    parameter int unsigned W = PIXEL_BIT_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] min_c,
    output logic [W-1:0] mid_c,
    output logic [W-1:0] max_c
);

    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] t;

    always_comb begin
        lo    = a;
        hi    = b;
        t     = '0;
        min_c = '0;
        mid_c = '0;
        max_c = c;
        if (b < a) begin
            lo = b;
            hi = a;
        end
        t = hi;
        if (hi > c) begin
            max_c = hi;
            t     = c;
        end
        min_c = lo;
        mid_c = t;
        if (t < lo) begin
            min_c = t;
            mid_c = lo;
        end
    end

endmodule

// File: rtl/filter_median_stream.sv
// Streaming 3x3 median filter: line buffers, raster tracking, 4-stage sort pipeline.
// Optional MEDIAN_BYPASS_EN adds bypass_i, which outputs the window centre instead.
module filter_median_stream
    import filter_pkg::*;
#(
    parameter int unsigned PIXEL_BIT  = PIXEL_BIT_DEF,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIXEL_BIT-1:0] pixel_i,
    input  logic                 valid_i,
    input  logic                 sof_i,
`ifdef MEDIAN_BYPASS_EN
    input  logic                 bypass_i,
`endif
    output logic [PIXEL_BIT-1:0] median_o,
    output logic                 valid_o,
    output logic                 sof_o,
    output logic                 eol_o
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned LB_W  = 2 * PIXEL_BIT;

    typedef logic [PIXEL_BIT-1:0] pix_t;

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;

    pix_t win_q [3][3];
    pix_t win_d [3][3];
    pix_t s1_min_q [3], s1_mid_q [3], s1_max_q [3];
    pix_t s1_min_d [3], s1_mid_d [3], s1_max_d [3];
    pix_t s1_min_c [3], s1_mid_c [3], s1_max_c [3];
    pix_t s2_lo_q, s2_md_q, s2_hi_q;
    pix_t s2_lo_d, s2_md_d, s2_hi_d;
    pix_t s2_lo_c, s2_md_c, s2_hi_c;
    pix_t s3_mid_c;
    pix_t median_q, median_d;
    tag_t tag_q [LATENCY];
    tag_t tag_d [LATENCY];
    tag_t tag_in;

    pix_t s2a_lo_unused, s2a_md_unused;
    pix_t s2b_lo_unused, s2b_hi_unused;
    pix_t s2c_md_unused, s2c_hi_unused;
    pix_t s3_lo_unused,  s3_hi_unused;

`ifdef MEDIAN_BYPASS_EN
    pix_t ctr1_q, ctr1_d, ctr2_q, ctr2_d;
`endif

    // Line buffer word holds {two rows up, one row up} for one column.
    logic [LB_W-1:0] lb_mem [IMG_WIDTH];
    logic [LB_W-1:0] lb_rd;
    logic [LB_W-1:0] lb_wdata;

    assign cur_col  = sof_i ? '0 : col_q;
    assign cur_row  = sof_i ? '0 : row_q;
    assign lb_rd    = lb_mem[cur_col];
    assign lb_wdata = {lb_rd[PIXEL_BIT-1:0], pixel_i};

    always_ff @(posedge clk) begin
        if (valid_i) begin
            lb_mem[cur_col] <= lb_wdata;
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_s1
        sort3 #(.W(PIXEL_BIT)) u_sort_row (
            .a     (win_q[r][0]),
            .b     (win_q[r][1]),
            .c     (win_q[r][2]),
            .min_c (s1_min_c[r]),
            .mid_c (s1_mid_c[r]),
            .max_c (s1_max_c[r])
        );
    end

    sort3 #(.W(PIXEL_BIT)) u_s2_mins (
        .a     (s1_min_q[0]), .b (s1_min_q[1]), .c (s1_min_q[2]),
        .min_c (s2a_lo_unused), .mid_c (s2a_md_unused), .max_c (s2_lo_c)
    );

    sort3 #(.W(PIXEL_BIT)) u_s2_mids (
        .a     (s1_mid_q[0]), .b (s1_mid_q[1]), .c (s1_mid_q[2]),
        .min_c (s2b_lo_unused), .mid_c (s2_md_c), .max_c (s2b_hi_unused)
    );

    sort3 #(.W(PIXEL_BIT)) u_s2_maxs (
        .a     (s1_max_q[0]), .b (s1_max_q[1]), .c (s1_max_q[2]),
        .min_c (s2_hi_c), .mid_c (s2c_md_unused), .max_c (s2c_hi_unused)
    );

    sort3 #(.W(PIXEL_BIT)) u_s3 (
        .a     (s2_lo_q), .b (s2_md_q), .c (s2_hi_q),
        .min_c (s3_lo_unused), .mid_c (s3_mid_c), .max_c (s3_hi_unused)
    );

    // Raster tracking, window shift and tag generation for the accepted pixel.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = win_q;
        tag_in = '0;
        if (valid_i) begin
            if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb_rd[LB_W-1:PIXEL_BIT];
            win_d[1][2] = lb_rd[PIXEL_BIT-1:0];
            win_d[2][2] = pixel_i;
            tag_in.valid = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            tag_in.sof   = tag_in.valid && (cur_row == ROW_W'(2)) && (cur_col == COL_W'(2));
            tag_in.eol   = tag_in.valid && (cur_col == COL_W'(IMG_WIDTH - 1));
`ifdef MEDIAN_BYPASS_EN
            tag_in.bypass = bypass_i;
`endif
        end
    end

    // Sort pipeline data and tag shift; tags move every cycle so gaps become bubbles.
    always_comb begin
        tag_d[0] = tag_in;
        for (int i = 1; i < int'(LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        s1_min_d = s1_min_c;
        s1_mid_d = s1_mid_c;
        s1_max_d = s1_max_c;
        s2_lo_d  = s2_lo_c;
        s2_md_d  = s2_md_c;
        s2_hi_d  = s2_hi_c;
        median_d = median_q;
`ifdef MEDIAN_BYPASS_EN
        ctr1_d = win_q[1][1];
        ctr2_d = ctr1_q;
        if (tag_q[2][TAG_VALID]) begin
            median_d = tag_q[2][TAG_BYPASS] ? ctr2_q : s3_mid_c;
        end
`else
        if (tag_q[2][TAG_VALID]) begin
            median_d = s3_mid_c;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            s2_lo_q  <= '0;
            s2_md_q  <= '0;
            s2_hi_q  <= '0;
            median_q <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
                s1_min_q[r] <= '0;
                s1_mid_q[r] <= '0;
                s1_max_q[r] <= '0;
            end
            for (int i = 0; i < int'(LATENCY); i++) begin
                tag_q[i] <= '0;
            end
`ifdef MEDIAN_BYPASS_EN
            ctr1_q <= '0;
            ctr2_q <= '0;
`endif
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            win_q    <= win_d;
            s1_min_q <= s1_min_d;
            s1_mid_q <= s1_mid_d;
            s1_max_q <= s1_max_d;
            s2_lo_q  <= s2_lo_d;
            s2_md_q  <= s2_md_d;
            s2_hi_q  <= s2_hi_d;
            median_q <= median_d;
            tag_q    <= tag_d;
`ifdef MEDIAN_BYPASS_EN
            ctr1_q <= ctr1_d;
            ctr2_q <= ctr2_d;
`endif
        end
    end

    assign median_o = median_q;
    assign valid_o  = tag_q[LATENCY-1][TAG_VALID];
    assign sof_o    = tag_q[LATENCY-1][TAG_SOF];
    assign eol_o    = tag_q[LATENCY-1][TAG_EOL];

endmodule

// File: tb/tb_filter_median_stream.sv
// Scoreboard bench for filter_median_stream on an 8x6 frame.
// Defining MEDIAN_BYPASS_EN also exercises the bypass path.
module tb_filter_median_stream;

    localparam int W = 8;
    localparam int H = 6;
`ifdef MEDIAN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_i;
    logic       valid_i;
    logic       sof_i;
`ifdef MEDIAN_BYPASS_EN
    logic       bypass_i;
`endif
    logic [7:0] median_o;
    logic       valid_o;
    logic       sof_o;
    logic       eol_o;

    filter_median_stream #(
        .PIXEL_BIT  (8),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pixel_i  (pixel_i),
        .valid_i  (valid_i),
        .sof_i    (sof_i),
`ifdef MEDIAN_BYPASS_EN
        .bypass_i (bypass_i),
`endif
        .median_o (median_o),
        .valid_o  (valid_o),
        .sof_o    (sof_o),
        .eol_o    (eol_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] med;
        logic       sof;
        logic       eol;
        int         due;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    int         res_cnt = 0;
    logic [7:0] last_med = 8'h00;
    bit         mon_en = 1'b0;
    int         mrow = 0;
    int         mcol = 0;
    logic [7:0] frame [H][W];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    // Reference median: plain insertion sort of the 9 window pixels.
    function automatic logic [7:0] med9(input int r, input int c);
        logic [7:0] v [9];
        logic [7:0] k;
        int n = 0;
        int j;
        for (int dr = -2; dr <= 0; dr++)
            for (int dc = -2; dc <= 0; dc++) begin
                v[n] = frame[r+dr][c+dc];
                n++;
            end
        for (int i = 1; i < 9; i++) begin
            k = v[i];
            j = i - 1;
            while (j >= 0 && v[j] > k) begin
                v[j+1] = v[j];
                j--;
            end
            v[j+1] = k;
        end
        return v[4];
    endfunction

    function automatic logic [7:0] pix_at(input int mode, input int r, input int c);
        case (mode)
            0: return 8'h40;
            1, 3: return (r == 3 && c == 3) ? 8'hFF : 8'h10;
            default: begin
                if (r < 3 && c < 3) begin
                    case (r * 3 + c)
                        0: return 8'd7;
                        1: return 8'd2;
                        2: return 8'd9;
                        3: return 8'd4;
                        4: return 8'd5;
                        5: return 8'd1;
                        6: return 8'd8;
                        7: return 8'd3;
                        default: return 8'd6;
                    endcase
                end
                return 8'($urandom_range(0, 255));
            end
        endcase
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] p, input bit s, input bit b);
        int   r;
        int   c;
        exp_t e;
        r = s ? 0 : mrow;
        c = s ? 0 : mcol;
        pixel_i = p;
        valid_i = 1'b1;
        sof_i   = s;
`ifdef MEDIAN_BYPASS_EN
        bypass_i = b;
`endif
        frame[r][c] = p;
        if (r >= 2 && c >= 2) begin
            e.med = (b && BYP) ? frame[r-1][c-1] : med9(r, c);
            e.sof = (r == 2 && c == 2);
            e.eol = (c == W - 1);
            e.due = cyc + 4;
            sb.push_back(e);
        end
        if (c == W - 1) begin
            mcol = 0;
            mrow = (r == H - 1) ? 0 : r + 1;
        end else begin
            mcol = c + 1;
            mrow = r;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        pixel_i = 8'($urandom_range(0, 255));
`ifdef MEDIAN_BYPASS_EN
        bypass_i = 1'b0;
`endif
    endtask

    // gap > 0: fixed idle cycles after each pixel; gap < 0: random 0..2.
    task automatic stream(input int mode, input int npix, input bit first_sof, input int gap);
        int r;
        int c;
        bit s;
        for (int i = 0; i < npix; i++) begin
            s = first_sof && (i == 0);
            r = s ? 0 : mrow;
            c = s ? 0 : mcol;
            send(pix_at(mode, r, c), s, (mode == 3) && (r == 4) && (c == 4));
            if (gap > 0) repeat (gap) idle();
            else if (gap < 0) repeat ($urandom_range(0, 2)) idle();
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle();
        chk(tag, 32'(sb.size()), 32'd0);
        repeat (3) idle();
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(valid_o), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("median", 32'(median_o), 32'(mon_e.med));
                    chk("sof", 32'(sof_o), 32'(mon_e.sof));
                    chk("eol", 32'(eol_o), 32'(mon_e.eol));
                    chk("latency", 32'(cyc), 32'(mon_e.due));
                    last_med = mon_e.med;
                    res_cnt++;
                end
            end else begin
                chk("hold", 32'(median_o), 32'(last_med));
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    chk("missing_valid", 32'(valid_o), 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        sof_i   = 1'b0;
        pixel_i = 8'h00;
`ifdef MEDIAN_BYPASS_EN
        bypass_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_median", 32'(median_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_sof", 32'(sof_o), 32'd0);
        chk("rst_eol", 32'(eol_o), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        idle();

        // flat frame
        res_cnt = 0;
        stream(0, W * H, 1'b1, 0);
        drain("t1_drain");
        chk("t1_count", 32'(res_cnt), 32'd24);

        // impulse noise, then scrambled 1..9 corner with random fill
        res_cnt = 0;
        stream(1, W * H, 1'b1, 0);
        drain("t2_drain");
        chk("t2_count", 32'(res_cnt), 32'd24);
        stream(2, W * H, 1'b1, 0);
        drain("t2b_drain");

        // bubbles: 1,0,0 pattern, then random gaps
        res_cnt = 0;
        stream(0, W * H, 1'b1, 2);
        drain("t3_drain");
        chk("t3_count", 32'(res_cnt), 32'd24);
        stream(2, W * H, 1'b1, -1);
        drain("t3b_drain");

        // resync: sof lands on pixel (3,4)
        stream(2, 3 * W + 4, 1'b1, 0);
        res_cnt = 0;
        stream(2, W * H, 1'b1, 0);
        drain("t4_drain");

        // reset while a result is on the output
        stream(2, 2 * W + 5, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            if (valid_o) break;
            idle();
        end
        chk("t5_saw_valid", 32'(valid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(valid_o), 32'd0);
        chk("t5_async_median", 32'(median_o), 32'd0);
        chk("t5_async_sof", 32'(sof_o), 32'd0);
        chk("t5_async_eol", 32'(eol_o), 32'd0);
        sb.delete();
        mrow = 0;
        mcol = 0;
        last_med = 8'h00;
        idle();
        rst = 1'b0;
        repeat (5) idle();
        res_cnt = 0;
        stream(2, W * H, 1'b0, 0);
        drain("t5_drain");
        chk("t5_count", 32'(res_cnt), 32'd24);

`ifdef MEDIAN_BYPASS_EN
        res_cnt = 0;
        stream(3, W * H, 1'b1, 0);
        drain("t6_drain");
        chk("t6_count", 32'(res_cnt), 32'd24);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
